// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing constants and helpers for the register write scoreboard.
package reg_scoreboard_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_W      = 4;
  localparam int CNT_W      = 2;
  localparam int TOT_W      = 5;
  // The status flags occupy one extra counter slot after the registers.
  localparam int STATUS_IDX = NUM_REGS;
  localparam int NUM_CNT    = NUM_REGS + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic logic [TOT_W-1:0] tot_ext(input logic b);
    return {{(TOT_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle between the ID stage and the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                flush;
  logic                issue_valid;
  logic                issue_wb_en;
  reg_idx_t            issue_dest;
  logic                issue_s;
  reg_idx_t            src1;
  reg_idx_t            src2;
  logic                src2_used;
  logic                use_status;
  logic                wb_valid;
  reg_idx_t            wb_dest;
  logic                status_retire;
  logic                hazard;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_vec;
  logic                status_busy;
  logic [TOT_W-1:0]    outstanding;
  logic                drained;
  logic                err;

  modport master (
    output flush, issue_valid, issue_wb_en, issue_dest, issue_s, src1, src2,
           src2_used, use_status, wb_valid, wb_dest, status_retire,
    input  hazard, issue_fire, busy_vec, status_busy, outstanding, drained, err
  );

  modport slave (
    input  flush, issue_valid, issue_wb_en, issue_dest, issue_s, src1, src2,
           src2_used, use_status, wb_valid, wb_dest, status_retire,
    output hazard, issue_fire, busy_vec, status_busy, outstanding, drained, err
  );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// Saturating up/down counter for one tracked register or the status flags.
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_nonzero,
  output logic o_at_max,
  output logic o_underflow,
  output logic o_overflow
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_nonzero;
  logic             w_at_max;

  assign w_nonzero = (r_cnt != CNT_ZERO);
  assign w_at_max  = (r_cnt == CNT_MAX);

  // Simultaneous inc and dec cancel; out-of-range steps hold the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_inc && !i_dec && !w_at_max) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else if (i_dec && !i_inc && w_nonzero) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_nonzero   = w_nonzero;
  assign o_at_max    = w_at_max;
  assign o_underflow = i_dec & ~i_inc & ~w_nonzero & ~i_clr;
  assign o_overflow  = i_inc & ~i_dec & w_at_max & ~i_clr;

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register and flag writes from issue to writeback and stalls RAW hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  sb
);

  logic [NUM_CNT-1:0]  w_inc;
  logic [NUM_CNT-1:0]  w_dec;
  logic [NUM_CNT-1:0]  w_nz;
  logic [NUM_CNT-1:0]  w_max;
  logic [NUM_CNT-1:0]  w_unf;
  logic [NUM_CNT-1:0]  w_ovf;
  logic [NUM_REGS-1:0] w_reg_nz;
  logic [NUM_REGS-1:0] w_reg_max;
  logic                w_hazard;
  logic                w_fire;
  logic                w_inc_eff;
  logic                w_dec_eff;
  logic [TOT_W-1:0]    r_outstanding;
  logic                r_err;

  assign w_reg_nz  = w_nz[NUM_REGS-1:0];
  assign w_reg_max = w_max[NUM_REGS-1:0];

  assign w_hazard = sb.issue_valid &
                    (  w_reg_nz[sb.src1]
                     | (sb.src2_used   & w_reg_nz[sb.src2])
                     | (sb.use_status  & w_nz[STATUS_IDX])
                     | (sb.issue_wb_en & w_reg_max[sb.issue_dest])
                     | (sb.issue_s     & w_max[STATUS_IDX]));

  assign w_fire = sb.issue_valid & ~w_hazard & ~sb.flush;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_ctl
    assign w_inc[g] = w_fire & sb.issue_wb_en & (sb.issue_dest == REG_W'(g));
    assign w_dec[g] = sb.wb_valid & ~sb.flush & (sb.wb_dest == REG_W'(g));
  end

  assign w_inc[STATUS_IDX] = w_fire & sb.issue_s;
  assign w_dec[STATUS_IDX] = sb.status_retire & ~sb.flush;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sb_counter u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inc       (w_inc[g]),
      .i_dec       (w_dec[g]),
      .i_clr       (sb.flush),
      .o_nonzero   (w_nz[g]),
      .o_at_max    (w_max[g]),
      .o_underflow (w_unf[g]),
      .o_overflow  (w_ovf[g])
    );
  end

  // Only steps that actually moved a register counter reach the total.
  assign w_inc_eff = |(w_inc[NUM_REGS-1:0] & ~w_ovf[NUM_REGS-1:0]);
  assign w_dec_eff = |(w_dec[NUM_REGS-1:0] & ~w_unf[NUM_REGS-1:0]);

  // Total in-flight register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= TOT_ZERO;
    end else if (sb.flush) begin
      r_outstanding <= TOT_ZERO;
    end else begin
      r_outstanding <= r_outstanding + tot_ext(w_inc_eff) - tot_ext(w_dec_eff);
    end
  end

  // Sticky error; flush leaves it alone so only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (|w_unf) | (|w_ovf);
    end
  end

  assign sb.hazard      = w_hazard;
  assign sb.issue_fire  = w_fire;
  assign sb.busy_vec    = w_reg_nz;
  assign sb.status_busy = w_nz[STATUS_IDX];
  assign sb.outstanding = r_outstanding;
  assign sb.drained     = (r_outstanding == TOT_ZERO) & ~w_nz[STATUS_IDX];
  assign sb.err         = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard with a queue of expected post-edge state.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_if();

  reg_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  typedef struct {
    logic fl, iv, wen; logic [3:0] dest; logic s;
    logic [3:0] s1, s2; logic s2u, ust, wbv; logic [3:0] wbd; logic sret;
    logic ehaz, efire; logic [15:0] ebusy; logic [4:0] eout; logic esb, eerr;
  } vec_t;

  typedef struct {
    logic [15:0] busy; logic [4:0] out; logic sb; logic err;
  } post_t;

  localparam int NV = 28;
  vec_t  vecs [NV];
  post_t exp_q[$];
  post_t p;
  int    n_vec  = 0;
  int    n_miss = 0;

  function automatic vec_t mk(
    input logic fl, input logic iv, input logic wen, input logic [3:0] dest,
    input logic s, input logic [3:0] s1, input logic [3:0] s2, input logic s2u,
    input logic ust, input logic wbv, input logic [3:0] wbd, input logic sret,
    input logic ehaz, input logic efire, input logic [15:0] ebusy,
    input logic [4:0] eout, input logic esb, input logic eerr);
    vec_t v;
    v.fl = fl; v.iv = iv; v.wen = wen; v.dest = dest; v.s = s;
    v.s1 = s1; v.s2 = s2; v.s2u = s2u; v.ust = ust; v.wbv = wbv;
    v.wbd = wbd; v.sret = sret; v.ehaz = ehaz; v.efire = efire;
    v.ebusy = ebusy; v.eout = eout; v.esb = esb; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.flush         = v.fl;
    sb_if.issue_valid   = v.iv;
    sb_if.issue_wb_en   = v.wen;
    sb_if.issue_dest    = v.dest;
    sb_if.issue_s       = v.s;
    sb_if.src1          = v.s1;
    sb_if.src2          = v.s2;
    sb_if.src2_used     = v.s2u;
    sb_if.use_status    = v.ust;
    sb_if.wb_valid      = v.wbv;
    sb_if.wb_dest       = v.wbd;
    sb_if.status_retire = v.sret;
  endtask

  task automatic chk_state(input string tag, input post_t e);
    chk({tag, ".busy_vec"},    32'(sb_if.busy_vec),    32'(e.busy));
    chk({tag, ".outstanding"}, 32'(sb_if.outstanding), 32'(e.out));
    chk({tag, ".status_busy"}, 32'(sb_if.status_busy), 32'(e.sb));
    chk({tag, ".drained"},     32'(sb_if.drained),     32'((e.out == 5'd0) && !e.sb));
    chk({tag, ".err"},         32'(sb_if.err),         32'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // RAW on R3: stall until retire, release one cycle later
    vecs[0]  = mk(O,I,I,4'd3,O,4'd1,4'd2,I,O,O,4'd0,O, O,I,16'h0008,5'd1,O,O);
    vecs[1]  = mk(O,I,I,4'd4,O,4'd3,4'd0,O,O,O,4'd0,O, I,O,16'h0008,5'd1,O,O);
    vecs[2]  = mk(O,I,I,4'd4,O,4'd3,4'd0,O,O,I,4'd3,O, I,O,16'h0000,5'd0,O,O);
    vecs[3]  = mk(O,I,I,4'd4,O,4'd3,4'd0,O,O,O,4'd0,O, O,I,16'h0010,5'd1,O,O);
    vecs[4]  = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,I,4'd4,O, O,O,16'h0000,5'd0,O,O);
    // Saturate R5, fourth write held until a retire
    vecs[5]  = mk(O,I,I,4'd5,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h0020,5'd1,O,O);
    vecs[6]  = mk(O,I,I,4'd5,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h0020,5'd2,O,O);
    vecs[7]  = mk(O,I,I,4'd5,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h0020,5'd3,O,O);
    vecs[8]  = mk(O,I,I,4'd5,O,4'd0,4'd0,O,O,O,4'd0,O, I,O,16'h0020,5'd3,O,O);
    vecs[9]  = mk(O,I,I,4'd5,O,4'd0,4'd0,O,O,I,4'd5,O, I,O,16'h0020,5'd2,O,O);
    vecs[10] = mk(O,I,I,4'd5,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h0020,5'd3,O,O);
    vecs[11] = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,I,4'd5,O, O,O,16'h0020,5'd2,O,O);
    vecs[12] = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,I,4'd5,O, O,O,16'h0020,5'd1,O,O);
    vecs[13] = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,I,4'd5,O, O,O,16'h0000,5'd0,O,O);
    // Same-cycle issue and retire of R2
    vecs[14] = mk(O,I,I,4'd2,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h0004,5'd1,O,O);
    vecs[15] = mk(O,I,I,4'd2,O,4'd0,4'd0,O,O,I,4'd2,O, O,I,16'h0004,5'd1,O,O);
    vecs[16] = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,I,4'd2,O, O,O,16'h0000,5'd0,O,O);
    // Flags: CMP, conditional MOV stalls, unconditional MOV does not
    vecs[17] = mk(O,I,O,4'd0,I,4'd1,4'd0,O,O,O,4'd0,O, O,I,16'h0000,5'd0,I,O);
    vecs[18] = mk(O,I,I,4'd6,O,4'd0,4'd0,O,I,O,4'd0,O, I,O,16'h0000,5'd0,I,O);
    vecs[19] = mk(O,I,I,4'd6,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h0040,5'd1,I,O);
    vecs[20] = mk(O,I,I,4'd7,O,4'd0,4'd0,O,I,O,4'd0,I, I,O,16'h0040,5'd1,O,O);
    vecs[21] = mk(O,I,I,4'd7,O,4'd0,4'd0,O,I,O,4'd0,O, O,I,16'h00C0,5'd2,O,O);
    // Build outstanding=4, flush with retire and issue, then stray retire
    vecs[22] = mk(O,I,I,4'd8,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h01C0,5'd3,O,O);
    vecs[23] = mk(O,I,I,4'd9,O,4'd0,4'd0,O,O,O,4'd0,O, O,I,16'h03C0,5'd4,O,O);
    vecs[24] = mk(I,I,I,4'd10,O,4'd0,4'd0,O,O,I,4'd6,O, O,O,16'h0000,5'd0,O,O);
    vecs[25] = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,I,4'd7,O, O,O,16'h0000,5'd0,O,I);
    vecs[26] = mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,O,4'd0,O, O,O,16'h0000,5'd0,O,I);
    vecs[27] = mk(I,O,O,4'd0,O,4'd0,4'd0,O,O,O,4'd0,O, O,O,16'h0000,5'd0,O,I);

    drive(mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,O,4'd0,O, O,O,16'h0,5'd0,O,O));
    #12;
    chk("reset.hazard", 32'(sb_if.hazard), 32'd0);
    p = '{busy: 16'h0, out: 5'd0, sb: 1'b0, err: 1'b0};
    chk_state("reset", p);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back('{busy: vecs[i].ebusy, out: vecs[i].eout, sb: vecs[i].esb, err: vecs[i].eerr});
      #1;
      chk($sformatf("v%0d.hazard", i),     32'(sb_if.hazard),     32'(vecs[i].ehaz));
      chk($sformatf("v%0d.issue_fire", i), 32'(sb_if.issue_fire), 32'(vecs[i].efire));
      @(posedge clk);
      #1;
      p = exp_q.pop_front();
      chk_state($sformatf("v%0d", i), p);
    end

    // Asynchronous reset mid-operation clears state and the sticky error
    @(negedge clk);
    drive(mk(O,I,I,4'd1,I,4'd0,4'd0,O,O,O,4'd0,O, O,O,16'h0,5'd0,O,O));
    @(posedge clk);
    #1;
    p = '{busy: 16'h0002, out: 5'd1, sb: 1'b1, err: 1'b1};
    chk_state("pre_rst", p);
    drive(mk(O,O,O,4'd0,O,4'd0,4'd0,O,O,O,4'd0,O, O,O,16'h0,5'd0,O,O));
    #2;
    rst_n = 1'b0;
    #1;
    p = '{busy: 16'h0, out: 5'd0, sb: 1'b0, err: 1'b0};
    chk_state("mid_rst", p);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post_rst", p);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
